// File: rtl/rvfi_bus_pkg.sv
// Shared types and helpers for the RVFI bus tracer.
// Each FIFO entry is sized for the widest supported bus (64-bit
// address and data). Narrower instances zero-fill the upper bits.
package rvfi_bus_pkg;

  localparam int TXN_ADDR_W = 64;
  localparam int TXN_DATA_W = 64;
  localparam int TXN_BE_W   = TXN_DATA_W / 8;

  // One accepted request, held until its response arrives
  typedef struct packed {
    logic                  instr;
    logic [TXN_ADDR_W-1:0] addr;
    logic                  we;
    logic [TXN_BE_W-1:0]   be;
    logic [TXN_DATA_W-1:0] wdata;
  } txn_t;

  // Number of byte lanes on a bus of the given data width
  function automatic int be_width(input int buslen);
    return buslen / 8;
  endfunction

  // Counter width able to hold 0..depth inclusive
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/rvfi_bus_tracer_if.sv
// Core-to-memory request/response bus as seen by the tracer.
// master: whoever drives the bus (core plus memory model).
// slave:  passive observers such as the tracer.
interface rvfi_bus_tracer_if #(
  parameter int XLEN   = 32,
  parameter int BUSLEN = 32
);

  logic                  bus_req;
  logic                  bus_gnt;
  logic                  bus_instr;
  logic [XLEN-1:0]       bus_addr;
  logic                  bus_we;
  logic [BUSLEN/8-1:0]   bus_be;
  logic [BUSLEN-1:0]     bus_wdata;
  logic                  bus_rvalid;
  logic [BUSLEN-1:0]     bus_rdata;
  logic                  bus_err;

  modport master (
    output bus_req, bus_gnt, bus_instr, bus_addr, bus_we, bus_be,
           bus_wdata, bus_rvalid, bus_rdata, bus_err
  );

  modport slave (
    input bus_req, bus_gnt, bus_instr, bus_addr, bus_we, bus_be,
          bus_wdata, bus_rvalid, bus_rdata, bus_err
  );

endinterface

// File: rtl/rvfi_bus_txn_fifo.sv
// In-order FIFO of outstanding bus transactions.
// A push into a full FIFO is accepted only when a pop happens in the
// same cycle. A pop from an empty FIFO is ignored.
module rvfi_bus_txn_fifo
  import rvfi_bus_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  txn_t                   push_data,
  input  logic                   pop,
  output txn_t                   head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = count_width(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  txn_t          mem_q [DEPTH];
  txn_t          mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_C);
  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

  // Next-state pointers, storage and occupancy; pointers wrap naturally
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state; reset forgets every in-flight entry
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage needs no reset: it is never read while empty
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/rvfi_bus_tracer.sv
// Passive RVFI bus tracer. Records each accepted request. When the
// in-order response arrives, it emits one registered trace record on
// the next cycle. It never drives or stalls the observed bus.
// XLEN and BUSLEN may not exceed 64.
module rvfi_bus_tracer
  import rvfi_bus_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int BUSLEN = 32,
  parameter int DEPTH  = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  rvfi_bus_tracer_if.slave       bus,
  output logic                   rvfi_bus_valid,
  output logic                   rvfi_bus_insn,
  output logic                   rvfi_bus_data,
  output logic                   rvfi_bus_fault,
  output logic [XLEN-1:0]        rvfi_bus_addr,
  output logic [BUSLEN/8-1:0]    rvfi_bus_rmask,
  output logic [BUSLEN/8-1:0]    rvfi_bus_wmask,
  output logic [BUSLEN-1:0]      rvfi_bus_rdata,
  output logic [BUSLEN-1:0]      rvfi_bus_wdata,
  output logic [$clog2(DEPTH):0] outstanding,
  output logic                   protocol_err
);

  localparam int BE_W = be_width(BUSLEN);

  txn_t                  push_entry, head;
  logic                  accept, pop_fire, fifo_full, fifo_empty;
  logic                  unused_head;
  logic                  valid_q, valid_d, insn_q, insn_d, data_q, data_d;
  logic                  fault_q, fault_d, perr_q, perr_d;
  logic [XLEN-1:0]       addr_q, addr_d;
  logic [BE_W-1:0]       rmask_q, rmask_d, wmask_q, wmask_d;
  logic [BUSLEN-1:0]     rdata_q, rdata_d, wdata_q, wdata_d;

  assign accept      = bus.bus_req && bus.bus_gnt;
  assign pop_fire    = bus.bus_rvalid && !fifo_empty;
  assign unused_head = ^head;

  // Capture the accepted request into a zero-filled FIFO entry
  always_comb begin
    push_entry                   = '0;
    push_entry.instr             = bus.bus_instr;
    push_entry.addr[XLEN-1:0]    = bus.bus_addr;
    push_entry.we                = bus.bus_we;
    push_entry.be[BE_W-1:0]      = bus.bus_be;
    push_entry.wdata[BUSLEN-1:0] = bus.bus_wdata;
  end

  rvfi_bus_txn_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (accept),
    .push_data (push_entry),
    .pop       (bus.bus_rvalid),
    .head      (head),
    .count     (outstanding),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Build the next trace record from the popped head and the response
  always_comb begin
    valid_d = 1'b0;
    insn_d  = 1'b0;
    data_d  = 1'b0;
    fault_d = 1'b0;
    addr_d  = '0;
    rmask_d = '0;
    wmask_d = '0;
    rdata_d = '0;
    wdata_d = '0;
    if (pop_fire) begin
      valid_d = 1'b1;
      insn_d  = head.instr;
      data_d  = !head.instr;
      fault_d = bus.bus_err;
      addr_d  = head.addr[XLEN-1:0];
      if (head.we) begin
        wmask_d = head.be[BE_W-1:0];
        wdata_d = head.wdata[BUSLEN-1:0];
      end else begin
        rmask_d = head.be[BE_W-1:0];
        rdata_d = bus.bus_rdata;
      end
    end
  end

  // Sticky flag for a response with nothing pending or an overflowing request
  always_comb begin
    perr_d = perr_q
           | (bus.bus_rvalid && fifo_empty)
           | (accept && fifo_full && !bus.bus_rvalid);
  end

  // Trace outputs and error flag are registered; reset wins over everything
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      insn_q  <= 1'b0;
      data_q  <= 1'b0;
      fault_q <= 1'b0;
      addr_q  <= '0;
      rmask_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
      wdata_q <= '0;
      perr_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      insn_q  <= insn_d;
      data_q  <= data_d;
      fault_q <= fault_d;
      addr_q  <= addr_d;
      rmask_q <= rmask_d;
      wmask_q <= wmask_d;
      rdata_q <= rdata_d;
      wdata_q <= wdata_d;
      perr_q  <= perr_d;
    end
  end

  assign rvfi_bus_valid = valid_q;
  assign rvfi_bus_insn  = insn_q;
  assign rvfi_bus_data  = data_q;
  assign rvfi_bus_fault = fault_q;
  assign rvfi_bus_addr  = addr_q;
  assign rvfi_bus_rmask = rmask_q;
  assign rvfi_bus_wmask = wmask_q;
  assign rvfi_bus_rdata = rdata_q;
  assign rvfi_bus_wdata = wdata_q;
  assign protocol_err   = perr_q;

endmodule

// File: tb/tb_rvfi_bus_tracer.sv
// Directed bench for rvfi_bus_tracer: a table of one-cycle vectors
// followed by hand-written reset and protocol-error sequences.
module tb_rvfi_bus_tracer;

  logic        clock = 1'b0;
  logic        reset;
  logic        rvfi_bus_valid, rvfi_bus_insn, rvfi_bus_data, rvfi_bus_fault;
  logic [31:0] rvfi_bus_addr, rvfi_bus_rdata, rvfi_bus_wdata;
  logic [3:0]  rvfi_bus_rmask, rvfi_bus_wmask;
  logic [2:0]  outstanding;
  logic        protocol_err;
  int          compared = 0;
  int          mismatched = 0;

  rvfi_bus_tracer_if #(.XLEN(32), .BUSLEN(32)) bus_if ();

  rvfi_bus_tracer #(.XLEN(32), .BUSLEN(32), .DEPTH(4)) dut (
    .clock          (clock),
    .reset          (reset),
    .bus            (bus_if),
    .rvfi_bus_valid (rvfi_bus_valid),
    .rvfi_bus_insn  (rvfi_bus_insn),
    .rvfi_bus_data  (rvfi_bus_data),
    .rvfi_bus_fault (rvfi_bus_fault),
    .rvfi_bus_addr  (rvfi_bus_addr),
    .rvfi_bus_rmask (rvfi_bus_rmask),
    .rvfi_bus_wmask (rvfi_bus_wmask),
    .rvfi_bus_rdata (rvfi_bus_rdata),
    .rvfi_bus_wdata (rvfi_bus_wdata),
    .outstanding    (outstanding),
    .protocol_err   (protocol_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        req, gnt, instr, we, rvalid, err;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  be;
    logic        e_valid, e_insn, e_data, e_fault, e_perr;
    logic [31:0] e_addr, e_rdata, e_wdata;
    logic [3:0]  e_rmask, e_wmask;
    logic [2:0]  e_outst;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk_row(
    input logic req, gnt, instr, input logic [31:0] addr, input logic we,
    input logic [3:0] be, input logic [31:0] wdata, input logic rvalid,
    input logic [31:0] rdata, input logic err,
    input logic e_valid, e_insn, e_data, e_fault, input logic [31:0] e_addr,
    input logic [3:0] e_rmask, e_wmask, input logic [31:0] e_rdata, e_wdata,
    input logic [2:0] e_outst, input logic e_perr);
    vec_t v;
    v.req = req; v.gnt = gnt; v.instr = instr; v.addr = addr; v.we = we;
    v.be = be; v.wdata = wdata; v.rvalid = rvalid; v.rdata = rdata; v.err = err;
    v.e_valid = e_valid; v.e_insn = e_insn; v.e_data = e_data;
    v.e_fault = e_fault; v.e_addr = e_addr; v.e_rmask = e_rmask;
    v.e_wmask = e_wmask; v.e_rdata = e_rdata; v.e_wdata = e_wdata;
    v.e_outst = e_outst; v.e_perr = e_perr;
    return v;
  endfunction

  // Idle bus, no trace expected
  function automatic vec_t idle_row(input logic [2:0] outst, input logic perr);
    return mk_row(0,0,0,0,0,0,0, 0,0,0, 0,0,0,0,0,0,0,0,0, outst, perr);
  endfunction

  // Drive one cycle of inputs, then sample just after the rising edge
  task automatic applyStimulus(input vec_t v);
    bus_if.bus_req    = v.req;
    bus_if.bus_gnt    = v.gnt;
    bus_if.bus_instr  = v.instr;
    bus_if.bus_addr   = v.addr;
    bus_if.bus_we     = v.we;
    bus_if.bus_be     = v.be;
    bus_if.bus_wdata  = v.wdata;
    bus_if.bus_rvalid = v.rvalid;
    bus_if.bus_rdata  = v.rdata;
    bus_if.bus_err    = v.err;
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input vec_t v);
    logic [111:0] act, exp;
    act = {rvfi_bus_valid, rvfi_bus_insn, rvfi_bus_data, rvfi_bus_fault,
           rvfi_bus_addr, rvfi_bus_rmask, rvfi_bus_wmask, rvfi_bus_rdata,
           rvfi_bus_wdata, outstanding, protocol_err};
    exp = {v.e_valid, v.e_insn, v.e_data, v.e_fault, v.e_addr, v.e_rmask,
           v.e_wmask, v.e_rdata, v.e_wdata, v.e_outst, v.e_perr};
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got v/i/d/f=%b%b%b%b addr=%h rm=%h wm=%h rd=%h wd=%h out=%0d perr=%b, expected v/i/d/f=%b%b%b%b addr=%h rm=%h wm=%h rd=%h wd=%h out=%0d perr=%b",
               name, rvfi_bus_valid, rvfi_bus_insn, rvfi_bus_data, rvfi_bus_fault,
               rvfi_bus_addr, rvfi_bus_rmask, rvfi_bus_wmask, rvfi_bus_rdata,
               rvfi_bus_wdata, outstanding, protocol_err,
               v.e_valid, v.e_insn, v.e_data, v.e_fault, v.e_addr, v.e_rmask,
               v.e_wmask, v.e_rdata, v.e_wdata, v.e_outst, v.e_perr);
    end
  endtask

  task automatic step(input string name, input vec_t v);
    applyStimulus(v);
    checkOutput(name, v);
  endtask

  initial begin
    // Read, write, faulting read
    vecs.push_back(mk_row(1,1,0,32'h100,0,4'hF,0, 0,0,0, 0,0,0,0,0,0,0,0,0, 1,0));
    vecs.push_back(mk_row(0,0,0,0,0,0,0, 1,32'hDEADBEEF,0,
                          1,0,1,0,32'h100,4'hF,4'h0,32'hDEADBEEF,0, 0,0));
    vecs.push_back(mk_row(1,1,0,32'h204,1,4'h3,32'h1234ABCD, 0,0,0, 0,0,0,0,0,0,0,0,0, 1,0));
    vecs.push_back(mk_row(0,0,0,0,0,0,0, 1,32'hFFFFFFFF,0,
                          1,0,1,0,32'h204,4'h0,4'h3,32'h0,32'h1234ABCD, 0,0));
    vecs.push_back(mk_row(1,1,0,32'h300,0,4'h6,0, 0,0,0, 0,0,0,0,0,0,0,0,0, 1,0));
    vecs.push_back(mk_row(0,0,0,0,0,0,0, 1,32'h55,1,
                          1,0,1,1,32'h300,4'h6,4'h0,32'h55,0, 0,0));
    // Four back-to-back fetches fill the FIFO
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk_row(1,1,1,32'h1000 + 32'(4*i),0,4'hF,0, 0,0,0,
                            0,0,0,0,0,0,0,0,0, 3'(i+1),0));
    vecs.push_back(idle_row(4, 0));
    // Fifth fetch accepted while the first response pops: still legal
    vecs.push_back(mk_row(1,1,1,32'h1010,0,4'hF,0, 1,32'h13,0,
                          1,1,0,0,32'h1000,4'hF,4'h0,32'h13,0, 4,0));
    for (int i = 1; i < 5; i++)
      vecs.push_back(mk_row(0,0,0,0,0,0,0, 1,32'h13 + 32'(i*128),0,
                            1,1,0,0,32'h1000 + 32'(4*i),4'hF,4'h0,32'h13 + 32'(i*128),0,
                            3'(4-i),0));
    vecs.push_back(idle_row(0, 0));
    // Overflow without a response drops the entry and flags the error
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk_row(1,1,0,32'h400 + 32'(4*i),0,4'hF,0, 0,0,0,
                            0,0,0,0,0,0,0,0,0, 3'(i+1),0));
    vecs.push_back(mk_row(1,1,0,32'h410,0,4'hF,0, 0,0,0, 0,0,0,0,0,0,0,0,0, 4,1));
    vecs.push_back(idle_row(4, 1));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk_row(0,0,0,0,0,0,0, 1,32'hA0 + 32'(i),0,
                            1,0,1,0,32'h400 + 32'(4*i),4'hF,4'h0,32'hA0 + 32'(i),0,
                            3'(3-i),1));
    vecs.push_back(idle_row(0, 1));

    // Reset state, with a request held during reset
    reset = 1'b1;
    applyStimulus(idle_row(0, 0));
    applyStimulus(idle_row(0, 0));
    step("reset_state", mk_row(1,1,0,32'h900,0,4'hF,0, 1,32'h1,0,
                               0,0,0,0,0,0,0,0,0, 0,0));
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++)
      step($sformatf("vec[%0d]", i), vecs[i]);

    // Reset clears the sticky error and takes priority over an accept
    reset = 1'b1;
    step("reset_prio", mk_row(1,1,0,32'h800,0,4'hF,0, 0,0,0, 0,0,0,0,0,0,0,0,0, 0,0));
    reset = 1'b0;
    step("first_accept", mk_row(1,1,0,32'h500,0,4'hF,0, 0,0,0, 0,0,0,0,0,0,0,0,0, 1,0));
    step("first_resp", mk_row(0,0,0,0,0,0,0, 1,32'hA5,0,
                              1,0,1,0,32'h500,4'hF,4'h0,32'hA5,0, 0,0));
    step("req_no_gnt", mk_row(1,0,0,32'h580,0,4'hF,0, 0,0,0, 0,0,0,0,0,0,0,0,0, 0,0));
    step("rvalid_empty", mk_row(0,0,0,0,0,0,0, 1,32'h66,0, 0,0,0,0,0,0,0,0,0, 0,1));
    step("fill_a", mk_row(1,1,0,32'h600,0,4'hF,0, 0,0,0, 0,0,0,0,0,0,0,0,0, 1,1));
    step("fill_b", mk_row(1,1,0,32'h604,0,4'hF,0, 0,0,0, 0,0,0,0,0,0,0,0,0, 2,1));
    reset = 1'b1;
    step("reset_inflight", idle_row(0, 0));
    reset = 1'b0;
    step("acc_rvalid_empty", mk_row(1,1,0,32'h700,0,4'hF,0, 1,32'h99,0,
                                    0,0,0,0,0,0,0,0,0, 1,1));
    step("resp_after_empty", mk_row(0,0,0,0,0,0,0, 1,32'h77,0,
                                    1,0,1,0,32'h700,4'hF,4'h0,32'h77,0, 0,1));
    step("idle_end", idle_row(0, 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
